spm_boot_loader: RTL and testbench

// Test-port initiator for the SPM: receives a byte-stream program image, writes it word by word into SPM

---
 rtl/spm_boot_loader_pkg.sv | 32 +++
 rtl/spm_boot_loader_if.sv | 29 ++
 rtl/spm_ld_byte_asm.sv | 30 +++
 rtl/spm_boot_loader.sv | 204 ++++++++++++++++++++
 tb/tb_spm_boot_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spm_boot_loader_pkg.sv
// Shared types and constants for the SPM boot loader: FSM states, test-port
// direction codes, load error codes and the wrapping SPM word-address helper.
package spm_boot_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WR,
        ST_CSUM,
        ST_VRD,
        ST_VCMP,
        ST_RUN,
        ST_ERR
    } spm_ld_state_e;

    localparam logic SPM_READ  = 1'b1;
    localparam logic SPM_WRITE = 1'b0;

    localparam logic [1:0] SPM_LD_ERR_NONE   = 2'b00;
    localparam logic [1:0] SPM_LD_ERR_LEN    = 2'b01;
    localparam logic [1:0] SPM_LD_ERR_CSUM   = 2'b10;
    localparam logic [1:0] SPM_LD_ERR_VERIFY = 2'b11;

    // Word address of image word k; the 30-bit add wraps naturally.
    function automatic logic [29:0] spm_word_addr(input logic [29:0] base,
                                                  input logic [15:0] k);
        return base + {14'd0, k};
    endfunction

endpackage

// File: rtl/spm_boot_loader_if.sv
// Byte-stream, control/status and SPM test-port signals of the boot loader.
// master = the loader, slave = the byte source / cpu_top side.
interface spm_boot_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [29:0] test_spm_addr;
    logic        test_spm_as_;
    logic        test_spm_rw;
    logic [31:0] test_spm_wr_data;
    logic [31:0] test_spm_rd_data;
    logic        cpu_en;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        input  start, rx_data, rx_valid, test_spm_rd_data,
        output rx_ready, test_spm_addr, test_spm_as_, test_spm_rw,
               test_spm_wr_data, cpu_en, busy, err, err_code
    );

    modport slave (
        output start, rx_data, rx_valid, test_spm_rd_data,
        input  rx_ready, test_spm_addr, test_spm_as_, test_spm_rw,
               test_spm_wr_data, cpu_en, busy, err, err_code
    );
endinterface

// File: rtl/spm_ld_byte_asm.sv
// Little-endian byte-to-word assembler. Bytes shift in from the top, so after
// four bytes word_q holds b3:b2:b1:b0; a 2-byte field sits in word_nxt[31:16].
module spm_ld_byte_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_nxt_o,
    output logic        word_valid_o
);
    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    assign word_nxt_o   = {byte_data_i, word_q[31:8]};
    assign word_valid_o = byte_vld_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (byte_vld_i) begin
            word_q <= word_nxt_o;
            cnt_q  <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/spm_boot_loader.sv
// SPM boot loader: receives LEN/DATA/CSUM byte image, writes it to SPM through
// the test port, reads it back to verify, then enables the CPU.
//
// state | meaning
// IDLE  | waiting for start after reset
// LEN0  | receiving length low byte
// LEN1  | receiving length high byte, range check
// DATA  | receiving 4 bytes of one image word
// WR    | single-cycle SPM write strobe, accumulate rx_sum
// CSUM  | receiving 4-byte checksum, compare with rx_sum
// VRD   | single-cycle SPM read strobe
// VCMP  | strobe released, read data accumulated into rb_sum
// RUN   | load good, cpu_en held until reset
// ERR   | load failed, waiting for a new start
module spm_boot_loader
    import spm_boot_loader_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0,
    parameter int          MAX_WORDS = 4096
) (
    input logic               clk,
    input logic               reset,
    spm_boot_loader_if.master bus
);
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    spm_ld_state_e state_q;
    logic          rx_ready_q;
    logic          as_q;
    logic          rw_q;
    logic [29:0]   addr_q;
    logic [31:0]   wr_data_q;
    logic          cpu_en_q;
    logic          busy_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic [15:0]   n_q;
    logic [15:0]   k_q;
    logic [31:0]   rx_sum_q;
    logic [31:0]   rb_sum_q;

    logic          rx_acc;
    logic          start_ok;
    logic          asm_clr;
    logic [31:0]   word_nxt;
    logic          word_valid;
    logic [15:0]   len;
    logic [15:0]   k_nxt;
    logic          last_word;
    logic [31:0]   rb_sum_d;

    assign rx_acc    = bus.rx_valid && rx_ready_q;
    assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
    assign asm_clr   = start_ok || ((state_q == ST_LEN1) && rx_acc);
    assign len       = word_nxt[31:16];
    assign k_nxt     = k_q + 16'd1;
    assign last_word = (k_q == (n_q - 16'd1));
    assign rb_sum_d  = rb_sum_q + bus.test_spm_rd_data;

    spm_ld_byte_asm u_asm (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (asm_clr),
        .byte_vld_i   (rx_acc),
        .byte_data_i  (bus.rx_data),
        .word_nxt_o   (word_nxt),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rx_ready_q <= 1'b0;
            as_q       <= 1'b1;
            rw_q       <= SPM_READ;
            addr_q     <= '0;
            wr_data_q  <= '0;
            cpu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= SPM_LD_ERR_NONE;
            n_q        <= '0;
            k_q        <= '0;
            rx_sum_q   <= '0;
            rb_sum_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (bus.start) begin
                        state_q    <= ST_LEN0;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        err_code_q <= SPM_LD_ERR_NONE;
                        k_q        <= '0;
                        rx_sum_q   <= '0;
                        rb_sum_q   <= '0;
                    end
                end
                ST_LEN0: begin
                    if (rx_acc) state_q <= ST_LEN1;
                end
                ST_LEN1: begin
                    if (rx_acc) begin
                        n_q <= len;
                        if ({1'b0, len} > MAX_W) begin
                            state_q    <= ST_ERR;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= SPM_LD_ERR_LEN;
                        end else if (len == 16'd0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        state_q    <= ST_WR;
                        rx_ready_q <= 1'b0;
                        as_q       <= 1'b0;
                        rw_q       <= SPM_WRITE;
                        addr_q     <= spm_word_addr(BASE_ADDR, k_q);
                        wr_data_q  <= word_nxt;
                    end
                end
                ST_WR: begin
                    as_q       <= 1'b1;
                    rw_q       <= SPM_READ;
                    rx_ready_q <= 1'b1;
                    rx_sum_q   <= rx_sum_q + wr_data_q;
                    if (last_word) begin
                        state_q <= ST_CSUM;
                    end else begin
                        k_q     <= k_nxt;
                        state_q <= ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (word_valid) begin
                        rx_ready_q <= 1'b0;
                        if (word_nxt != rx_sum_q) begin
                            state_q    <= ST_ERR;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= SPM_LD_ERR_CSUM;
                        end else if (n_q == 16'd0) begin
                            state_q  <= ST_RUN;
                            busy_q   <= 1'b0;
                            cpu_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_VRD;
                            k_q     <= '0;
                            as_q    <= 1'b0;
                            rw_q    <= SPM_READ;
                            addr_q  <= spm_word_addr(BASE_ADDR, 16'd0);
                        end
                    end
                end
                ST_VRD: begin
                    state_q <= ST_VCMP;
                    as_q    <= 1'b1;
                end
                ST_VCMP: begin
                    rb_sum_q <= rb_sum_d;
                    if (last_word) begin
                        busy_q <= 1'b0;
                        if (rb_sum_d == rx_sum_q) begin
                            state_q  <= ST_RUN;
                            cpu_en_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= SPM_LD_ERR_VERIFY;
                        end
                    end else begin
                        k_q     <= k_nxt;
                        state_q <= ST_VRD;
                        as_q    <= 1'b0;
                        addr_q  <= spm_word_addr(BASE_ADDR, k_nxt);
                    end
                end
                ST_RUN: begin
                    as_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready         = rx_ready_q;
    assign bus.test_spm_addr    = addr_q;
    assign bus.test_spm_as_     = as_q;
    assign bus.test_spm_rw      = rw_q;
    assign bus.test_spm_wr_data = wr_data_q;
    assign bus.cpu_en           = cpu_en_q;
    assign bus.busy             = busy_q;
    assign bus.err              = err_q;
    assign bus.err_code         = err_code_q;
endmodule

// File: tb/tb_spm_boot_loader.sv
// Directed bench for spm_boot_loader with an SPM model and write/read scoreboards.
module tb_spm_boot_loader;
    import spm_boot_loader_pkg::*;

    localparam logic [29:0] BASE = 30'h0;
    localparam int          MAXW = 4096;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spm_boot_loader_if bus ();

    spm_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem [0:15];
    logic [31:0] img [0:7];
    int          corrupt_idx = -1;
    logic        prev_as = 1'b1;
    logic [61:0] exp_wr [$];
    logic [29:0] exp_rd [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; at the falling edge service the SPM model and scoreboards.
    task automatic cycle();
        logic [61:0] e;
        logic [29:0] ra;
        @(negedge clk);
        if (bus.test_spm_as_ === 1'b0) begin
            chk("as_gap", 64'(prev_as), 64'd1);
            chk("rx_ready_in_access", 64'(bus.rx_ready), 64'd0);
            if (bus.test_spm_rw === SPM_WRITE) begin
                chk("write_expected", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(bus.test_spm_addr), 64'(e[61:32]));
                    chk("wr_data", 64'(bus.test_spm_wr_data), 64'(e[31:0]));
                end
                mem[bus.test_spm_addr[3:0]] = bus.test_spm_wr_data;
            end else begin
                chk("read_expected", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) begin
                    ra = exp_rd.pop_front();
                    chk("rd_addr", 64'(bus.test_spm_addr), 64'(ra));
                end
                bus.test_spm_rd_data = mem[bus.test_spm_addr[3:0]] ^
                    ((int'(bus.test_spm_addr) == corrupt_idx) ? 32'h1 : 32'h0);
            end
        end
        prev_as = bus.test_spm_as_;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic acc;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.rx_valid = 1'b0;
                cycle();
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = bus.rx_ready;
            cycle();
        end
        bus.rx_valid = 1'b0;
        chk("byte_accepted", 64'(acc), 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic send_len(input logic [15:0] n, input bit gaps);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("err_cleared_on_start", 64'(bus.err), 64'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && bus.busy !== 1'b0; i++) cycle();
        chk("load_done", 64'(bus.busy), 64'd0);
        repeat (3) cycle();
        chk("all_writes_seen", 64'(exp_wr.size()), 64'd0);
        chk("all_reads_seen", 64'(exp_rd.size()), 64'd0);
    endtask

    // Full load of img[0:n-1]; reads are expected only when the checksum is good.
    task automatic run_image(input int n, input logic [31:0] csum, input bit gaps, input bit reads);
        pulse_start();
        send_len(16'(n), gaps);
        for (int k = 0; k < n; k++) begin
            exp_wr.push_back({BASE + 30'(k), img[k]});
            if (reads) exp_rd.push_back(BASE + 30'(k));
        end
        for (int k = 0; k < n; k++) send_word(img[k], gaps);
        send_word(csum, gaps);
        wait_idle();
    endtask

    function automatic logic [31:0] img_sum(input int n);
        logic [31:0] s = 32'h0;
        for (int k = 0; k < n; k++) s = s + img[k];
        return s;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
        chk({tag, "_as"}, 64'(bus.test_spm_as_), 64'd1);
        chk({tag, "_rw"}, 64'(bus.test_spm_rw), 64'(SPM_READ));
        chk({tag, "_addr"}, 64'(bus.test_spm_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(bus.test_spm_wr_data), 64'd0);
        chk({tag, "_cpu_en"}, 64'(bus.cpu_en), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_err_code"}, 64'(bus.err_code), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) cycle();
        chk_reset_vals("reset");
        exp_wr.delete();
        exp_rd.delete();
        reset = 1'b1;
        cycle();
    endtask

    initial begin
        bus.start            = 1'b0;
        bus.rx_valid         = 1'b0;
        bus.rx_data          = 8'h00;
        bus.test_spm_rd_data = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        do_reset();

        // Length one past the limit: rejected before any SPM access.
        pulse_start();
        send_len(16'(MAXW + 1), 1'b0);
        chk("len_err", 64'(bus.err), 64'd1);
        chk("len_err_code", 64'(bus.err_code), 64'(SPM_LD_ERR_LEN));
        chk("len_busy", 64'(bus.busy), 64'd0);
        repeat (5) cycle();
        chk("len_no_strobe", 64'(bus.test_spm_as_), 64'd1);
        chk("len_cpu_en", 64'(bus.cpu_en), 64'd0);
        chk("len_rx_ready", 64'(bus.rx_ready), 64'd0);

        // Bad stream checksum: one write, no readback.
        img[0] = 32'h5;
        run_image(1, 32'h6, 1'b0, 1'b0);
        chk("csum_err", 64'(bus.err), 64'd1);
        chk("csum_err_code", 64'(bus.err_code), 64'(SPM_LD_ERR_CSUM));
        chk("csum_cpu_en", 64'(bus.cpu_en), 64'd0);

        // Readback corruption of word 1, then the same image loads cleanly.
        img[0] = 32'hCAFE0001;
        img[1] = 32'h0BAD0002;
        img[2] = 32'h12345678;
        corrupt_idx = 1;
        run_image(3, img_sum(3), 1'b0, 1'b1);
        chk("verify_err", 64'(bus.err), 64'd1);
        chk("verify_err_code", 64'(bus.err_code), 64'(SPM_LD_ERR_VERIFY));
        chk("verify_cpu_en", 64'(bus.cpu_en), 64'd0);
        corrupt_idx = -1;
        run_image(3, img_sum(3), 1'b0, 1'b1);
        chk("reload_cpu_en", 64'(bus.cpu_en), 64'd1);
        chk("reload_err", 64'(bus.err), 64'd0);
        chk("reload_err_code", 64'(bus.err_code), 64'd0);

        // Empty image: no strobes at all, straight to RUN.
        do_reset();
        run_image(0, 32'h0, 1'b0, 1'b0);
        chk("empty_cpu_en", 64'(bus.cpu_en), 64'd1);
        chk("empty_err", 64'(bus.err), 64'd0);

        // Reference image; first LEN byte is presented while start pulses.
        do_reset();
        img[0] = 32'h11223344;
        img[1] = 32'hAABBCCDD;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h02;
        run_image(2, 32'hBBDE0021, 1'b0, 1'b1);
        chk("ref_cpu_en", 64'(bus.cpu_en), 64'd1);
        chk("ref_err", 64'(bus.err), 64'd0);
        chk("ref_mem0", 64'(mem[0]), 64'h11223344);
        chk("ref_mem1", 64'(mem[1]), 64'hAABBCCDD);
        repeat (4) cycle();
        chk("run_port_idle", 64'(bus.test_spm_as_), 64'd1);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("run_ignores_start", 64'(bus.busy), 64'd0);

        // Reset in the middle of DATA with random valid gaps, then restart.
        do_reset();
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h01020304;
        pulse_start();
        send_len(16'd2, 1'b1);
        exp_wr.push_back({BASE, img[0]});
        send_word(img[0], 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h03, 1'b1);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #2;
        chk_reset_vals("async_reset");
        do_reset();
        run_image(2, img_sum(2), 1'b1, 1'b1);
        chk("restart_cpu_en", 64'(bus.cpu_en), 64'd1);
        chk("restart_err", 64'(bus.err), 64'd0);
        chk("restart_mem1", 64'(mem[1]), 64'h01020304);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
